// File: rtl/fir_ctrl_pkg.sv
// Shared types and defaults for the FIR tap sequencer and its address counter.
package fir_ctrl_pkg;

  localparam int TAPS_DEFAULT   = 64;
  localparam int ADDR_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/tap_counter.sv
// Tap address counter: counts 0..TAPS-1, wraps to 0 after the last tap,
// and flags the last tap so the sequencer can leave the accumulate phase.
module tap_counter
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS   = TAPS_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;
  logic              at_last;

  assign at_last = (count_q == LAST_IDX);

  // Wrapping at the last tap keeps the address inside 0..TAPS-1 at all times.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = at_last;

endmodule

// File: rtl/tap_sequencer.sv
// Sequencer for the tapped shift register and MAC: accepts a sample, pulses
// shift, walks taps 0..TAPS-1 with the MAC enabled, then holds the result.
module tap_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS   = TAPS_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  output logic              shift,
  output logic [ADDR_W-1:0] address,
  output logic              macEn,
  output logic              macFirst,
  output logic              macLast,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy
);

  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              last_tap;
  logic              in_acc;

  assign in_acc = (state_q == ACC);

  // Held clear outside ACC so every sample starts from tap 0.
  tap_counter #(
    .TAPS  (TAPS),
    .ADDR_W(ADDR_W)
  ) u_tap_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!in_acc),
    .en_i   (in_acc),
    .count_o(addr_q),
    .last_o (last_tap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only inReady and shift depend on inputs; everything else decodes state.
  always_comb begin
    state_d = state_q;
    inReady = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) begin
          shift   = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        if (last_tap) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (outReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign address  = addr_q;
  assign macEn    = in_acc;
  assign macFirst = in_acc && (addr_q == '0);
  assign macLast  = in_acc && last_tap;
  assign outValid = (state_q == DONE);
  assign busy     = (state_q != IDLE);

endmodule
